// File: rtl/elevator_pkg.sv
// Shared elevator constants and types, used by the car controller and the queue-update logic.
package elevator_pkg;

  localparam int unsigned LVL_W       = 2;
  localparam int unsigned NUM_LVLS    = 4;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned TAIL_W      = 3;

  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_LVLS - 1);
  localparam logic [LVL_W-1:0] BOT_LVL = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } car_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } car_dir_e;

endpackage

// File: rtl/elevator_car_timer.sv
// Loadable down-counter with a zero flag; shared by floor travel and door hold.
module car_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: walks the car one floor at a time toward the queue head
// and holds the doors open whenever the queue logic reports a stop at the current floor.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_DEPTH*LVL_W-1:0] queue,
  input  logic [TAIL_W-1:0]            tail,
  input  logic                         stop_at_pos_lvl,
  output logic [LVL_W-1:0]             pos_lvl,
  output logic                         moving_up,
  output logic                         moving_down,
  output logic                         door_open,
  output logic                         arrived
);

  localparam int unsigned MAX_CYCLES = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES);
  localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_CYCLES - 1);

  car_state_e         r_state, w_state_nxt;
  car_dir_e           r_dir, w_dir_nxt;
  logic [LVL_W-1:0]   r_pos_lvl, w_pos_nxt;
  logic               r_moving_up, r_moving_down, r_door_open, r_arrived;
  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  logic               w_tmr_zero;
  logic [LVL_W-1:0]   w_head;
  logic               w_unused_queue;

  // Only the head entry steers the car; deeper entries belong to the queue logic.
  assign w_head         = queue[LVL_W-1:0];
  assign w_unused_queue = ^queue[QUEUE_DEPTH*LVL_W-1:LVL_W];

  car_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero_c   (w_tmr_zero)
  );

  // Next-state, direction, position and timer-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pos_nxt   = r_pos_lvl;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    unique case (r_state)
      IDLE: begin
        if (stop_at_pos_lvl) begin
          w_state_nxt = DOOR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = DOOR_LOAD;
        end else if (tail != '0) begin
          if (w_head > r_pos_lvl) begin
            w_state_nxt = MOVE;
            w_dir_nxt   = DIR_UP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = FLOOR_LOAD;
          end else if (w_head < r_pos_lvl) begin
            w_state_nxt = MOVE;
            w_dir_nxt   = DIR_DOWN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = FLOOR_LOAD;
          end
        end
      end
      MOVE: begin
        if (w_tmr_zero) begin
          w_state_nxt = IDLE;
          if ((r_dir == DIR_UP) && (r_pos_lvl != TOP_LVL)) begin
            w_pos_nxt = r_pos_lvl + LVL_W'(1);
          end else if ((r_dir == DIR_DOWN) && (r_pos_lvl != BOT_LVL)) begin
            w_pos_nxt = r_pos_lvl - LVL_W'(1);
          end
        end
      end
      DOOR: begin
        if (stop_at_pos_lvl) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_LOAD;
        end else if (w_tmr_zero) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dir         <= DIR_UP;
      r_pos_lvl     <= '0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
      r_arrived     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dir         <= w_dir_nxt;
      r_pos_lvl     <= w_pos_nxt;
      r_moving_up   <= (w_state_nxt == MOVE) && (w_dir_nxt == DIR_UP);
      r_moving_down <= (w_state_nxt == MOVE) && (w_dir_nxt == DIR_DOWN);
      r_door_open   <= (w_state_nxt == DOOR);
      r_arrived     <= (r_state == MOVE) && (w_state_nxt == IDLE);
    end
  end

  assign pos_lvl     = r_pos_lvl;
  assign moving_up   = r_moving_up;
  assign moving_down = r_moving_down;
  assign door_open   = r_door_open;
  assign arrived     = r_arrived;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: trips are predicted arithmetically from floor distance,
// floor/door durations and reopen pulses, then compared cycle by cycle.
module tb_elevator_car_ctrl;

  localparam int FC = 4;
  localparam int DC = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] queue;
  logic [2:0] tail;
  logic       stop_at_pos_lvl;
  logic [1:0] pos_lvl;
  logic       moving_up, moving_down, door_open, arrived;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_pos  = 0;

  elevator_car_ctrl #(
    .FLOOR_CYCLES (FC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .queue           (queue),
    .tail            (tail),
    .stop_at_pos_lvl (stop_at_pos_lvl),
    .pos_lvl         (pos_lvl),
    .moving_up       (moving_up),
    .moving_down     (moving_down),
    .door_open       (door_open),
    .arrived         (arrived)
  );

  always #5 clk = ~clk;

  // Expected {pos, up, down, door, arrived} at cycle k of a trip from p to t.
  // Each hop is one IDLE cycle plus FC MOVE cycles; door lasts DC cycles from the last stop pulse.
  function automatic logic [5:0] trip_model(input int k, input int p, input int t, input int r);
    int d, s, arrive, close, hop, off, lvl;
    logic up, dn, door, arr;
    d = (t > p) ? t - p : p - t;
    s = (t > p) ? 1 : -1;
    arrive = d * (FC + 1);
    up = 1'b0; dn = 1'b0; door = 1'b0; arr = 1'b0;
    if (k < arrive) begin
      hop = k / (FC + 1);
      off = k % (FC + 1);
      lvl = p + s * hop;
      if (off != 0) begin
        up = (s > 0);
        dn = (s < 0);
      end else begin
        arr = (hop > 0);
      end
    end else begin
      lvl   = t;
      close = arrive + DC;
      if (r > arrive && r <= close) close = r + DC;
      door = (k > arrive) && (k <= close);
      arr  = (k == arrive) && (d > 0);
    end
    return {2'(lvl), up, dn, door, arr};
  endfunction

  function automatic int trip_close(input int p, input int t, input int r);
    int arrive, close;
    arrive = ((t > p) ? t - p : p - t) * (FC + 1);
    close  = arrive + DC;
    if (r > arrive && r <= close) close = r + DC;
    return close;
  endfunction

  task automatic do_reset();
    rst = 1'b1; tail = '0; queue = '0; stop_at_pos_lvl = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur_pos = 0;
  endtask

  // Drives one request to floor t (queue logic modelled as a timeline) and checks every cycle.
  // tz keeps tail at 0; abort_k >= 0 asserts rst in that cycle instead of continuing.
  task automatic run_trip(input int p, input int t, input int r, input bit tz,
                          input int abort_k, input string name);
    int arrive, close;
    logic [5:0] got, exp;
    arrive = ((t > p) ? t - p : p - t) * (FC + 1);
    close  = trip_close(p, t, r);
    for (int k = 0; k <= close; k++) begin
      got = {pos_lvl, moving_up, moving_down, door_open, arrived};
      exp = trip_model(k, p, t, r);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s k=%0d {pos,up,dn,door,arr} got=%b expected=%b", name, k, got, exp);
      end
      if (k == abort_k) begin
        rst = 1'b1; stop_at_pos_lvl = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; tail = '0;
        got = {pos_lvl, moving_up, moving_down, door_open, arrived};
        n_checks++;
        if (got !== 6'b0) begin
          n_fail++;
          $display("FAIL %s_after_reset got=%b expected=000000", name, got);
        end
        cur_pos = 0;
        return;
      end
      tail  = (tz || k > arrive) ? 3'd0 : 3'($urandom_range(1, 7));
      queue = {6'($urandom), 2'(t)};
      stop_at_pos_lvl = (k == arrive) || (k == r);
      @(posedge clk); #1;
    end
    cur_pos = t;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    got = {pos_lvl, moving_up, moving_down, door_open, arrived};
    n_checks++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b expected=000000", got);
    end
  endtask

  task automatic test_empty_queue();
    logic [5:0] got;
    for (int c = 0; c < 20; c++) begin
      tail = '0; stop_at_pos_lvl = 1'b0; queue = 8'($urandom);
      @(posedge clk); #1;
      got = {pos_lvl, moving_up, moving_down, door_open, arrived};
      n_checks++;
      if (got !== 6'b0) begin
        n_fail++;
        $display("FAIL empty_queue c=%0d got=%b expected=000000", c, got);
      end
    end
  endtask

  task automatic test_head_at_floor();
    logic [5:0] got, exp;
    exp = {2'(cur_pos), 4'b0};
    for (int c = 0; c < 6; c++) begin
      tail = 3'($urandom_range(1, 7)); stop_at_pos_lvl = 1'b0;
      queue = {6'($urandom), 2'(cur_pos)};
      @(posedge clk); #1;
      got = {pos_lvl, moving_up, moving_down, door_open, arrived};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL head_at_floor c=%0d got=%b expected=%b", c, got, exp);
      end
    end
    tail = '0;
  endtask

  task automatic test_two_floor_up();
    do_reset();
    run_trip(0, 2, -1, 1'b0, -1, "two_floor_up");
  endtask

  task automatic test_reversal();
    run_trip(cur_pos, 0, -1, 1'b0, -1, "reversal");
  endtask

  task automatic test_door_reopen();
    do_reset();
    run_trip(0, 2, 13, 1'b0, -1, "door_reopen");
  endtask

  task automatic test_current_floor_press();
    run_trip(cur_pos, cur_pos, -1, 1'b1, -1, "current_floor_press");
  endtask

  task automatic test_reset_mid_move();
    run_trip(cur_pos, 0, -1, 1'b0, 3, "reset_mid_move");
    run_trip(0, 3, -1, 1'b0, FC + 4, "reset_mid_move_hop2");
    run_trip(0, 1, -1, 1'b0, FC + 3, "reset_mid_door");
  endtask

  task automatic test_random_trips();
    int t, r, arrive;
    for (int n = 0; n < 30; n++) begin
      t = $urandom_range(0, 3);
      arrive = ((t > cur_pos) ? t - cur_pos : cur_pos - t) * (FC + 1);
      r = ($urandom_range(0, 1) == 1) ? arrive + $urandom_range(1, DC) : -1;
      run_trip(cur_pos, t, r, 1'b0, -1, "random_trip");
    end
    run_trip(cur_pos, cur_pos, -1, 1'b1, -1, "random_tail_press");
  endtask

  initial begin
    rst = 1'b1; queue = '0; tail = '0; stop_at_pos_lvl = 1'b0;
    test_reset();
    test_empty_queue();
    test_two_floor_up();
    test_reversal();
    test_door_reopen();
    test_head_at_floor();
    test_current_floor_press();
    test_reset_mid_move();
    test_random_trips();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
